audio_rx_frame_ctrl: RTL

- Controller that sequences the I2S/left-justified ADC receive path in the aud_bclk domain.
- Measures aud_lrc half-periods, acquires and monitors frame lock, and issues per-channel capture starts to the bit-level receiver.
- Pairs returned left/right words into stereo frames and buffers them in a 2-entry FIFO with valid/ready towards the downstream FFT/processing path.
- Reports lock status, sync errors and overflow.

---
 rtl/audio_rx_frame_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/audio_rx_frame_ctrl.sv
// Frame controller for the I2S/left-justified ADC receive path: LRC lock tracking,
// per-channel capture sequencing, left/right pairing and a 2-entry stereo output FIFO.
module audio_rx_frame_ctrl #(
    parameter int unsigned WL          = 32,
    parameter int unsigned MAX_HALF    = 64,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic          aud_bclk,
    input  logic          sys_rst,
    input  logic          en,
    input  logic          aud_lrc,
    output logic          rx_start,
    output logic          rx_ch,
    input  logic          sample_valid,
    input  logic [WL-1:0] sample_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_left,
    output logic [WL-1:0] out_right,
    output logic          locked,
    output logic [7:0]    sync_err_cnt,
    output logic          overflow,
    input  logic          clr
);

    localparam int unsigned HPW = 7;
    localparam int unsigned GCW = 4;
    localparam int unsigned EW  = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [GCW-1:0]   good_cnt, good_n;
    logic             lrc_d0;
    logic [HPW-1:0]   hp_cnt;
    logic             lrc_edge;
    logic [HPW:0]     half_len;
    logic             half_ok;
    logic             timeout;
    logic             bad_half;
    logic             lose;
    logic             issue;

    logic             pending;
    logic             left_held;
    logic [WL-1:0]    left_word;
    logic             take;
    logic             word_left;
    logic             word_right;
    logic             push_req;

    logic             t_valid;
    logic [WL-1:0]    t_left, t_right;
    logic             nh_valid, nt_valid;
    logic [WL-1:0]    nh_left, nh_right, nt_left, nt_right;
    logic             pop, full, push_ok, drop;

    // Half-period measurement: length is judged on the edge cycle as hp_cnt + 1.
    assign lrc_edge = aud_lrc ^ lrc_d0;
    assign half_len = {1'b0, hp_cnt} + (HPW+1)'(1);
    assign half_ok  = (half_len >= (HPW+1)'(WL)) && (half_len <= (HPW+1)'(MAX_HALF));
    assign timeout  = !lrc_edge && (hp_cnt == HPW'(MAX_HALF));
    assign bad_half = (lrc_edge && !half_ok) || timeout;

    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            lrc_d0 <= 1'b0;
            hp_cnt <= '0;
        end else begin
            lrc_d0 <= aud_lrc;
            if (lrc_edge)
                hp_cnt <= '0;
            else if (hp_cnt != {HPW{1'b1}})
                hp_cnt <= hp_cnt + HPW'(1);
        end
    end

    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

    // Lock FSM; the entry edge into LOCKING only starts measurement.
    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        lose    = 1'b0;
        case (state)
            UNLOCKED: begin
                good_n = '0;
                if (lrc_edge)
                    state_n = LOCKING;
            end
            LOCKING: begin
                if (lrc_edge && half_ok) begin
                    if (good_cnt == GCW'(LOCK_FRAMES - 1)) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good_cnt + GCW'(1);
                    end
                end else if (bad_half) begin
                    good_n = '0;
                end
            end
            LOCKED: begin
                if (bad_half) begin
                    state_n = UNLOCKED;
                    lose    = 1'b1;
                end
            end
            default: state_n = UNLOCKED;
        endcase
        if (!en) begin
            state_n = UNLOCKED;
            good_n  = '0;
            lose    = 1'b0;
        end
    end

    assign issue      = lrc_edge && (state_n == LOCKED);
    assign take       = sample_valid && pending;
    assign word_left  = take && !rx_ch;
    assign word_right = take && rx_ch;
    assign push_req   = word_right && left_held;

    // Capture sequencing and left/right pairing; a word in the issue cycle belongs to the old channel.
    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            locked    <= 1'b0;
            rx_start  <= 1'b0;
            rx_ch     <= 1'b0;
            pending   <= 1'b0;
            left_held <= 1'b0;
            left_word <= '0;
        end else begin
            locked   <= (state_n == LOCKED);
            rx_start <= issue;
            if (issue)
                rx_ch <= aud_lrc;
            if (issue)
                pending <= 1'b1;
            else if (lose || take)
                pending <= 1'b0;
            if (word_left)
                left_word <= sample_data;
            if (lose)
                left_held <= 1'b0;
            else if (word_left)
                left_held <= 1'b1;
            else if (word_right)
                left_held <= 1'b0;
        end
    end

    // Two-entry FIFO: head lives in the output registers, tail behind it.
    always_comb begin
        pop      = out_valid && out_ready;
        full     = out_valid && t_valid;
        push_ok  = push_req && !(full && !pop);
        drop     = push_req && full && !pop;
        nh_valid = out_valid;
        nh_left  = out_left;
        nh_right = out_right;
        nt_valid = t_valid;
        nt_left  = t_left;
        nt_right = t_right;
        if (pop) begin
            nh_valid = t_valid;
            nh_left  = t_left;
            nh_right = t_right;
            nt_valid = 1'b0;
        end
        if (push_ok) begin
            if (!nh_valid) begin
                nh_valid = 1'b1;
                nh_left  = left_word;
                nh_right = sample_data;
            end else begin
                nt_valid = 1'b1;
                nt_left  = left_word;
                nt_right = sample_data;
            end
        end
    end

    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            t_valid   <= 1'b0;
            t_left    <= '0;
            t_right   <= '0;
        end else begin
            out_valid <= nh_valid;
            out_left  <= nh_left;
            out_right <= nh_right;
            t_valid   <= nt_valid;
            t_left    <= nt_left;
            t_right   <= nt_right;
        end
    end

    // Status: a new event takes priority over a coincident clear.
    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            overflow     <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clr)
                overflow <= 1'b0;
            if (lose) begin
                if (clr)
                    sync_err_cnt <= EW'(1);
                else if (sync_err_cnt != {EW{1'b1}})
                    sync_err_cnt <= sync_err_cnt + EW'(1);
            end else if (clr) begin
                sync_err_cnt <= '0;
            end
        end
    end

endmodule
